// File: rtl/eprisc_bus_master_pkg.sv
// eprisc_bus_pkg: shared types and constants for the epRISC bus master
package eprisc_bus_pkg;
  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;
  localparam logic [1:0] SEL_NONE = 2'd0;
  localparam logic [1:0] SEL_DEV1 = 2'd1;
  localparam logic [1:0] SEL_DEV2 = 2'd2;
  localparam logic [1:0] SEL_DEV3 = 2'd3;
  localparam int BUS_BYTES_MAX = 4;
endpackage

// File: rtl/eprisc_bus_master_if.sv
// eprisc_bus_master_if: core command port and peripheral bus of the bus master
interface eprisc_bus_master_if;
  logic        iStart;
  logic [1:0]  iSelect;
  logic [1:0]  iLength;
  logic [31:0] iData;
  logic [31:0] oData;
  logic        oBusy;
  logic        oDone;
  logic        oInterrupt;
  logic [7:0]  oBusMOSI;
  logic [7:0]  iBusMISO;
  logic        oBusClock;
  logic [1:0]  oBusSelect;
  logic        iBusInterrupt;
  modport master (
    input  iStart, iSelect, iLength, iData, iBusMISO, iBusInterrupt,
    output oData, oBusy, oDone, oInterrupt, oBusMOSI, oBusClock, oBusSelect
  );
  modport slave (
    output iStart, iSelect, iLength, iData, iBusMISO, iBusInterrupt,
    input  oData, oBusy, oDone, oInterrupt, oBusMOSI, oBusClock, oBusSelect
  );
endinterface

// File: rtl/eprisc_sync2.sv
// eprisc_sync2: two-flop synchronizer for a single asynchronous level
module eprisc_sync2 (
  input  logic iClk,
  input  logic iRst,
  input  logic d,
  output logic q
);
  logic meta;
  // shift the level through two flops so q lags d by exactly two edges
  always_ff @(posedge iClk)
    if (iRst) {q, meta} <= 2'b00;
    else {q, meta} <= {meta, d};
endmodule

// File: rtl/eprisc_bus_master.sv
// eprisc_bus_master: byte-wide full-duplex serial bus master with interrupt sync
module eprisc_bus_master
  import eprisc_bus_pkg::*;
#(
  parameter int CLKDIV = 4
) (
  input logic iClk,
  input logic iRst,
  eprisc_bus_master_if.master bus
);
  localparam int CW = $clog2(CLKDIV + 1);
  localparam logic [CW-1:0] RELOAD = CW'(CLKDIV - 1);
  state_t state;
  logic [CW-1:0] phase;
  logic [1:0] bytes;
  logic [23:0] tx;
  logic expire;
  assign expire = phase == '0;
  eprisc_sync2 u_sync (
    .iClk(iClk),
    .iRst(iRst),
    .d(bus.iBusInterrupt),
    .q(bus.oInterrupt)
  );
  // transfer FSM: half-period timer drives bus clock edges, MISO sampled on rise
  always_ff @(posedge iClk)
    if (iRst) begin
      state <= IDLE;
      phase <= '0;
      bytes <= '0;
      tx <= '0;
      bus.oData <= '0;
      bus.oBusy <= 1'b0;
      bus.oDone <= 1'b0;
      bus.oBusMOSI <= '0;
      bus.oBusClock <= 1'b0;
      bus.oBusSelect <= SEL_NONE;
    end else
      case (state)
        IDLE:
          if (bus.iStart && bus.iSelect != SEL_NONE) begin
            tx <= bus.iData[23:0];
            bytes <= bus.iLength;
            bus.oData <= '0;
            bus.oBusSelect <= bus.iSelect;
            bus.oBusMOSI <= bus.iData[31:24];
            bus.oBusy <= 1'b1;
            bus.oBusClock <= 1'b0;
            phase <= RELOAD;
            state <= LOW;
          end
        LOW:
          if (expire) begin
            bus.oBusClock <= 1'b1;
            bus.oData <= {bus.oData[23:0], bus.iBusMISO};
            phase <= RELOAD;
            state <= HIGH;
          end else phase <= phase - 1'b1;
        HIGH:
          if (expire) begin
            bus.oBusClock <= 1'b0;
            phase <= RELOAD;
            if (bytes != 2'd0) begin
              bytes <= bytes - 2'd1;
              tx <= {tx[15:0], 8'h00};
              bus.oBusMOSI <= tx[23:16];
              state <= LOW;
            end else begin
              bus.oBusSelect <= SEL_NONE;
              bus.oBusy <= 1'b0;
              bus.oDone <= 1'b1;
              bus.oBusMOSI <= '0;
              state <= DONE;
            end
          end else phase <= phase - 1'b1;
        DONE: begin
          bus.oDone <= 1'b0;
          state <= IDLE;
        end
      endcase
endmodule

// File: tb/tb_eprisc_bus_master.sv
// tb_eprisc_bus_master: directed vectors and corner sequences for the bus master
module tb_eprisc_bus_master;
  import eprisc_bus_pkg::*;
  typedef struct {
    logic [1:0]  sel;
    logic [1:0]  len;
    logic [31:0] data;
    logic [31:0] miso;
    logic [31:0] rdata;
    int          cycles;
    bit          inject;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  vec_t vecs[4];
  eprisc_bus_master_if b4();
  eprisc_bus_master_if b1();
  eprisc_bus_master #(.CLKDIV(4)) dut4 (.iClk(clk), .iRst(rst), .bus(b4));
  eprisc_bus_master #(.CLKDIV(1)) dut1 (.iClk(clk), .iRst(rst), .bus(b1));
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic run(input vec_t v);
    int c, k;
    logic prev;
    bit done;
    logic [31:0] m, d;
    b4.iSelect = v.sel;
    b4.iLength = v.len;
    b4.iData = v.data;
    b4.iBusMISO = v.miso[31:24];
    b4.iStart = 1'b1;
    tick();
    b4.iStart = 1'b0;
    check("accept_busy", 32'(b4.oBusy), 32'd1);
    check("accept_sel", 32'(b4.oBusSelect), 32'(v.sel));
    check("accept_mosi", 32'(b4.oBusMOSI), 32'(v.data[31:24]));
    check("accept_data", b4.oData, 32'd0);
    k = 0;
    c = 0;
    prev = 1'b0;
    done = 1'b0;
    while (!done && c < 200) begin
      if (v.inject && c == 5) begin
        b4.iStart = 1'b1;
        b4.iSelect = SEL_DEV3;
        b4.iLength = 2'd0;
        b4.iData = 32'hFFFF_FFFF;
      end
      tick();
      c++;
      if (c == 6) b4.iStart = 1'b0;
      if (b4.oBusClock && !prev) begin
        d = v.data << (8 * k);
        check("mosi_at_rise", 32'(b4.oBusMOSI), 32'(d[31:24]));
        check("sel_at_rise", 32'(b4.oBusSelect), 32'(v.sel));
        k++;
        m = v.miso << (8 * k);
        b4.iBusMISO = m[31:24];
      end
      prev = b4.oBusClock;
      done = b4.oDone;
    end
    check("done_cycle", c, v.cycles);
    check("rise_count", k, int'(v.len) + 1);
    check("rx_word", b4.oData, v.rdata);
    check("done_sel_idle", 32'(b4.oBusSelect), 32'd0);
    if (v.inject) begin
      b4.iStart = 1'b1;
      b4.iSelect = SEL_DEV1;
    end
    tick();
    b4.iStart = 1'b0;
    check("done_pulse_end", 32'(b4.oDone), 32'd0);
    check("no_accept_in_done", 32'(b4.oBusy), 32'd0);
  endtask
  task automatic irq_pulse(input string name);
    b4.iBusInterrupt = 1'b1;
    tick();
    check({name, "_rise1"}, 32'(b4.oInterrupt), 32'd0);
    tick();
    check({name, "_rise2"}, 32'(b4.oInterrupt), 32'd1);
    b4.iBusInterrupt = 1'b0;
    tick();
    check({name, "_fall1"}, 32'(b4.oInterrupt), 32'd1);
    tick();
    check({name, "_fall2"}, 32'(b4.oInterrupt), 32'd0);
  endtask
  initial begin
    int c, k;
    logic prev;
    bit seen;
    logic [3:0] exp_clk;
    vecs[0] = '{SEL_DEV2, 2'd3, 32'hA1B2_C3D4, 32'h1122_3344, 32'h1122_3344, 32, 1'b1};
    vecs[1] = '{SEL_DEV1, 2'd0, 32'h5A00_0000, 32'hC300_0000, 32'h0000_00C3, 8, 1'b0};
    vecs[2] = '{SEL_DEV3, 2'd1, 32'hDEAD_BEEF, 32'h9A7B_0000, 32'h0000_9A7B, 16, 1'b0};
    vecs[3] = '{SEL_DEV1, 2'd2, 32'h0102_0304, 32'hF00F_AA00, 32'h00F0_0FAA, 24, 1'b1};
    b4.iStart = 1'b0; b4.iSelect = 2'd0; b4.iLength = 2'd0; b4.iData = '0;
    b4.iBusMISO = '0; b4.iBusInterrupt = 1'b0;
    b1.iStart = 1'b0; b1.iSelect = 2'd0; b1.iLength = 2'd0; b1.iData = '0;
    b1.iBusMISO = '0; b1.iBusInterrupt = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    check("rst_busy", 32'(b4.oBusy), 32'd0);
    check("rst_done", 32'(b4.oDone), 32'd0);
    check("rst_data", b4.oData, 32'd0);
    check("rst_mosi", 32'(b4.oBusMOSI), 32'd0);
    check("rst_clock", 32'(b4.oBusClock), 32'd0);
    check("rst_sel", 32'(b4.oBusSelect), 32'd0);
    check("rst_irq", 32'(b4.oInterrupt), 32'd0);
    rst = 1'b0;
    tick();
    b4.iStart = 1'b1; b4.iSelect = SEL_NONE; b4.iData = 32'h1234_5678; b4.iLength = 2'd3;
    tick();
    b4.iStart = 1'b0;
    check("sel0_busy", 32'(b4.oBusy), 32'd0);
    check("sel0_sel", 32'(b4.oBusSelect), 32'd0);
    tick();
    for (int i = 0; i < 4; i++) run(vecs[i]);
    b4.iSelect = SEL_DEV2; b4.iLength = 2'd3; b4.iData = 32'hA1B2_C3D4; b4.iStart = 1'b1;
    tick();
    b4.iStart = 1'b0;
    k = 0; c = 0; prev = 1'b0;
    while (k < 2 && c < 100) begin
      tick();
      c++;
      if (b4.oBusClock && !prev) k++;
      prev = b4.oBusClock;
    end
    check("mid_rises", k, 2);
    check("mid_clock_high", 32'(b4.oBusClock), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_sel", 32'(b4.oBusSelect), 32'd0);
    check("mid_rst_clock", 32'(b4.oBusClock), 32'd0);
    check("mid_rst_busy", 32'(b4.oBusy), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      seen |= b4.oDone;
      tick();
    end
    check("mid_rst_nodone", 32'(seen), 32'd0);
    irq_pulse("irq_idle");
    b4.iSelect = SEL_DEV1; b4.iLength = 2'd0; b4.iData = 32'h5A00_0000; b4.iStart = 1'b1;
    tick();
    b4.iStart = 1'b0;
    irq_pulse("irq_busy");
    check("irq_busy_still", 32'(b4.oBusy), 32'd1);
    c = 4;
    while (!b4.oDone && c < 100) begin
      tick();
      c++;
    end
    check("irq_xfer_done", c, 8);
    tick();
    exp_clk = 4'b0101;
    b1.iSelect = SEL_DEV3; b1.iLength = 2'd1; b1.iData = 32'h1234_0000;
    b1.iBusMISO = 8'h5C; b1.iStart = 1'b1;
    tick();
    b1.iStart = 1'b0;
    check("div1_mosi0", 32'(b1.oBusMOSI), 32'h12);
    for (int i = 1; i <= 4; i++) begin
      tick();
      if (i == 1) b1.iBusMISO = 8'hE7;
      check("div1_clock", 32'(b1.oBusClock), 32'(exp_clk[i-1]));
      check("div1_done", 32'(b1.oDone), 32'(i == 4));
      if (i == 2) check("div1_mosi1", 32'(b1.oBusMOSI), 32'h34);
    end
    check("div1_rx", b1.oData, 32'h0000_5CE7);
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
